// File: rtl/musedash_pkg.sv
// rtl/musedash_pkg.sv - shared grade encodings and BCD score constants
package musedash_pkg;

    localparam int          BCD_W     = 4;
    localparam logic [15:0] SCORE_SAT = 16'h9999;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_GREAT   = 2'd2,
        GRADE_PERFECT = 2'd3
    } grade_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single BCD digit adder with carry in/out
module bcd_digit_add
    import musedash_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic [BCD_W-1:0] addend,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] raw;

    always_comb begin
        raw  = {1'b0, digit} + {1'b0, addend} + {{BCD_W{1'b0}}, cin};
        sum  = raw[BCD_W-1:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = BCD_W'(raw - 5'd10);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_bcd_accum.sv
// rtl/score_bcd_accum.sv - 4-digit BCD score accumulator and combo tracker
module score_bcd_accum
    import musedash_pkg::*;
#(
    parameter int unsigned PTS_GOOD       = 1,
    parameter int unsigned PTS_GREAT      = 3,
    parameter int unsigned PTS_PERFECT    = 5,
    parameter int unsigned COMBO_BONUS_TH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        hit_valid,
    input  logic [1:0]  hit_grade,
    output logic        hit_ready,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo,
    output logic        score_sat
);

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] work;
    logic [3:0]  addend;
    logic        carry;

    logic [3:0]  base_pts;
    logic [3:0]  hit_addend;
    logic [3:0]  dig;
    logic [3:0]  dig_add;
    logic [3:0]  sum;
    logic        cout;

    assign hit_ready = (state == ST_IDLE);

    // Bonus is judged on the combo as it stood before this hit.
    always_comb begin
        base_pts = 4'd0;
        case (grade_t'(hit_grade))
            GRADE_GOOD:    base_pts = 4'(PTS_GOOD);
            GRADE_GREAT:   base_pts = 4'(PTS_GREAT);
            GRADE_PERFECT: base_pts = 4'(PTS_PERFECT);
            default:       base_pts = 4'd0;
        endcase
        hit_addend = base_pts + ((32'(combo) >= COMBO_BONUS_TH) ? 4'd1 : 4'd0);
    end

    assign dig     = work[{idx, 2'b00} +: 4];
    assign dig_add = (idx == 2'd0) ? addend : 4'd0;

    bcd_digit_add u_digit_add (
        .digit  (dig),
        .addend (dig_add),
        .cin    (carry),
        .sum    (sum),
        .cout   (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            work      <= 16'h0000;
            addend    <= 4'd0;
            carry     <= 1'b0;
            score_bcd <= 16'h0000;
            combo     <= 8'd0;
            score_sat <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            carry     <= 1'b0;
            score_bcd <= 16'h0000;
            combo     <= 8'd0;
            score_sat <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit_valid) begin
                        if (grade_t'(hit_grade) == GRADE_MISS) begin
                            combo <= 8'd0;
                        end else begin
                            combo  <= (combo == 8'hff) ? 8'hff : combo + 8'd1;
                            addend <= hit_addend;
                            work   <= score_bcd;
                            carry  <= 1'b0;
                            idx    <= 2'd0;
                            state  <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    if (idx == 2'd3) begin
                        // Carry out of the top digit pins the score at 9999 for good.
                        if (cout) begin
                            score_bcd <= SCORE_SAT;
                            score_sat <= 1'b1;
                        end else begin
                            score_bcd <= {sum, work[11:0]};
                        end
                        state <= ST_IDLE;
                    end else begin
                        work[{idx, 2'b00} +: 4] <= sum;
                        carry <= cout;
                        idx   <= idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_accum.sv
// tb/tb_score_bcd_accum.sv - self-checking bench for score_bcd_accum
module tb_score_bcd_accum;
    import musedash_pkg::*;

    localparam int PG  = 1;
    localparam int PGR = 3;
    localparam int PP  = 5;
    localparam int TH  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        hit_valid;
    logic [1:0]  hit_grade;
    logic        hit_ready;
    logic [15:0] score_bcd;
    logic [7:0]  combo;
    logic        score_sat;

    int checks = 0;
    int errors = 0;

    int m_score = 0;
    int m_combo = 0;
    bit m_sat   = 1'b0;

    typedef struct {
        logic [1:0]  g;
        logic [15:0] score;
        logic [7:0]  combo;
    } vec_t;

    vec_t tbl[15];

    score_bcd_accum #(
        .PTS_GOOD       (PG),
        .PTS_GREAT      (PGR),
        .PTS_PERFECT    (PP),
        .COMBO_BONUS_TH (TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .hit_valid (hit_valid),
        .hit_grade (hit_grade),
        .hit_ready (hit_ready),
        .score_bcd (score_bcd),
        .combo     (combo),
        .score_sat (score_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pts(input logic [1:0] g);
        case (g)
            2'd1:    return PG;
            2'd2:    return PGR;
            2'd3:    return PP;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int addend_of(input logic [1:0] g);
        return pts(g) + ((m_combo >= TH) ? 1 : 0);
    endfunction

    task automatic model_accept(input logic [1:0] g);
        if (g == 2'd0) begin
            m_combo = 0;
        end else begin
            m_score = m_score + addend_of(g);
            m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
            if (m_score > 9999) begin
                m_score = 9999;
                m_sat   = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_score = 0;
        m_combo = 0;
        m_sat   = 1'b0;
    endtask

    task automatic check_state(input string name);
        check({name, "_score"}, score_bcd, to_bcd(m_score));
        check({name, "_combo"}, combo, m_combo);
        check({name, "_sat"}, score_sat, m_sat);
        check({name, "_ready"}, hit_ready, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!hit_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", hit_ready, 1);
    endtask

    // Starts and ends on a falling edge; noise drives junk hits while busy.
    task automatic hit(input logic [1:0] g, input bit noise);
        logic [15:0] prev;
        wait_ready();
        prev      = score_bcd;
        hit_valid = 1'b1;
        hit_grade = g;
        @(negedge clk);
        hit_valid = 1'b0;
        model_accept(g);
        check("combo_at_accept", combo, m_combo);
        if (g != 2'd0) begin
            for (int k = 0; k < 4; k++) begin
                check("ready_busy", hit_ready, 0);
                check("score_hidden", score_bcd, prev);
                if (noise) begin
                    hit_valid = 1'($urandom % 2);
                    hit_grade = 2'($urandom % 4);
                end
                @(negedge clk);
            end
            hit_valid = 1'b0;
        end
        check_state("after_hit");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        check_state("clear");
    endtask

    task automatic preload(input int target);
        int guard = 0;
        logic [1:0] g;
        do_clear();
        while (m_score < target && guard < 5000) begin
            if (addend_of(2'd3) <= target - m_score)      g = 2'd3;
            else if (addend_of(2'd2) <= target - m_score) g = 2'd2;
            else if (addend_of(2'd1) <= target - m_score) g = 2'd1;
            else                                          g = 2'd0;
            hit(g, 1'b0);
            guard++;
        end
        check("preload_score", score_bcd, to_bcd(target));
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        hit_valid = 1'b0;
        hit_grade = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_score", score_bcd, 16'h0000);
        check("reset_combo", combo, 8'd0);
        check("reset_sat", score_sat, 1'b0);
        check("reset_ready", hit_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add
        hit(GRADE_PERFECT, 1'b0);
        check("basic_score", score_bcd, 16'h0005);
        check("basic_combo", combo, 8'd1);

        // Table: combo bonus and MISS, from a cleared score
        tbl[0]  = '{GRADE_GOOD,    16'h0001, 8'd1};
        tbl[1]  = '{GRADE_GOOD,    16'h0002, 8'd2};
        tbl[2]  = '{GRADE_GOOD,    16'h0003, 8'd3};
        tbl[3]  = '{GRADE_GOOD,    16'h0004, 8'd4};
        tbl[4]  = '{GRADE_GOOD,    16'h0005, 8'd5};
        tbl[5]  = '{GRADE_GOOD,    16'h0006, 8'd6};
        tbl[6]  = '{GRADE_GOOD,    16'h0007, 8'd7};
        tbl[7]  = '{GRADE_GOOD,    16'h0008, 8'd8};
        tbl[8]  = '{GRADE_GOOD,    16'h0009, 8'd9};
        tbl[9]  = '{GRADE_GOOD,    16'h0010, 8'd10};
        tbl[10] = '{GRADE_GOOD,    16'h0012, 8'd11};
        tbl[11] = '{GRADE_GREAT,   16'h0016, 8'd12};
        tbl[12] = '{GRADE_PERFECT, 16'h0022, 8'd13};
        tbl[13] = '{GRADE_MISS,    16'h0022, 8'd0};
        tbl[14] = '{GRADE_GOOD,    16'h0023, 8'd1};
        do_clear();
        for (int i = 0; i < 15; i++) begin
            hit(tbl[i].g, 1'b0);
            check("tbl_score", score_bcd, tbl[i].score);
            check("tbl_combo", combo, tbl[i].combo);
        end

        // Carry ripple 0998 + 3 -> 1001
        preload(998);
        hit(GRADE_MISS, 1'b0);
        hit(GRADE_GREAT, 1'b0);
        check("ripple_score", score_bcd, 16'h1001);

        // Saturation
        preload(9998);
        hit(GRADE_MISS, 1'b0);
        hit(GRADE_PERFECT, 1'b0);
        check("sat_score", score_bcd, 16'h9999);
        check("sat_flag", score_sat, 1'b1);
        hit(GRADE_GOOD, 1'b0);
        check("sat_hold_score", score_bcd, 16'h9999);
        check("sat_hold_combo", combo, 8'd2);

        // Clear sampled at E2 of an addition, with a competing hit on the same edge
        hit_valid = 1'b1;
        hit_grade = GRADE_PERFECT;
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
        clear     = 1'b1;
        hit_valid = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        hit_valid = 1'b0;
        model_reset();
        check_state("clear_mid");
        repeat (5) @(negedge clk);
        check_state("clear_mid_later");

        // Asynchronous reset mid-addition
        hit(GRADE_GOOD, 1'b0);
        hit_valid = 1'b1;
        hit_grade = GRADE_PERFECT;
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("async_reset_later");

        // Back-pressure: continuous PERFECT requests
        hit_valid = 1'b1;
        hit_grade = GRADE_PERFECT;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("bp_combo", combo, 8'(k / 5 + 1));
            check("bp_ready", hit_ready, (k % 5) == 4);
        end
        hit_valid = 1'b0;
        check("bp_score", score_bcd, 16'h0015);
        check("bp_combo_final", combo, 8'd3);
        m_score = 15;
        m_combo = 3;
        @(negedge clk);
        check_state("bp_idle");

        // Randomized hits with junk requests while busy and occasional clears
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) do_clear();
            else hit(2'($urandom % 4), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
